// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (CPU, debug/loader) in front of a single-port 32-word data memory.
// Latency: request sampled in IDLE -> gnt + memory strobe next cycle -> rvalid the cycle after (3 cycles/txn).
// Backpressure: one transaction in flight; a losing requester holds req and is taken at the next IDLE.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request (held stable until cpu_gnt)
//   cpu_gnt/rvalid/rdata/err   CPU grant pulse, response pulse, read data, out-of-range flag
//   dbg_*                      same set for the debug/loader port
//   mem_addr/wdata             registered memory address and write data
//   mem_write/mem_read         one-cycle memory strobes, asserted only in ACCESS
//   mem_rdata                  combinational read data from memory
module data_mem_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int CPU_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_owner_q;
  logic              we_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pick_dbg;
  logic              any_req;
  logic [31:0]       sel_addr;

  assign any_req  = cpu_req | dbg_req;
  assign sel_addr = pick_dbg ? dbg_addr : cpu_addr;

  // Winner selection. In round-robin mode a tie goes to whoever did not
  // win last; last_owner resets to DBG so the CPU takes the first tie.
  always_comb begin
    pick_dbg = 1'b0;
    if (CPU_PRIORITY != 0) begin
      pick_dbg = dbg_req & ~cpu_req;
    end else begin
      pick_dbg = dbg_req & (~cpu_req | (last_owner_q == OWN_CPU));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q      <= pick_dbg;
        last_owner_q <= pick_dbg;
        we_q         <= pick_dbg ? dbg_we : cpu_we;
        err_q        <= |sel_addr[31:ADDR_W];
        mem_addr     <= sel_addr;
        mem_wdata    <= pick_dbg ? dbg_wdata : cpu_wdata;
      end
      // Writes and out-of-range accesses return zero read data.
      if (state_q == ACCESS) begin
        rdata_q <= (!we_q && !err_q) ? mem_rdata : '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    cpu_rdata  = '0;
    dbg_rdata  = '0;
    cpu_err    = 1'b0;
    dbg_err    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = ACCESS;
      end
      ACCESS: begin
        cpu_gnt   = (owner_q == OWN_CPU);
        dbg_gnt   = (owner_q == OWN_DBG);
        mem_write = we_q & ~err_q;
        mem_read  = ~we_q & ~err_q;
        state_d   = RESP;
      end
      RESP: begin
        if (owner_q == OWN_DBG) begin
          dbg_rvalid = 1'b1;
          dbg_rdata  = rdata_q;
          dbg_err    = err_q;
        end else begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = rdata_q;
          cpu_err    = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  // Second instance in fixed-priority mode; read-only, memory ties to zero.
  logic        p_cpu_req, p_dbg_req;
  logic        p_cpu_gnt, p_cpu_rvalid, p_cpu_err, p_dbg_gnt, p_dbg_rvalid, p_dbg_err;
  logic [31:0] p_cpu_rdata, p_dbg_rdata, p_mem_addr, p_mem_wdata;
  logic        p_mem_write, p_mem_read;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .CPU_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  data_mem_arbiter #(.ADDR_W(5), .DATA_W(32), .CPU_PRIORITY(1)) dut_pri (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(p_cpu_req), .cpu_we(1'b0), .cpu_addr(32'd1), .cpu_wdata(32'd0),
    .cpu_gnt(p_cpu_gnt), .cpu_rvalid(p_cpu_rvalid), .cpu_rdata(p_cpu_rdata), .cpu_err(p_cpu_err),
    .dbg_req(p_dbg_req), .dbg_we(1'b0), .dbg_addr(32'd2), .dbg_wdata(32'd0),
    .dbg_gnt(p_dbg_gnt), .dbg_rvalid(p_dbg_rvalid), .dbg_rdata(p_dbg_rdata), .dbg_err(p_dbg_err),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_write(p_mem_write), .mem_read(p_mem_read),
    .mem_rdata(32'd0)
  );

  // Memory model: combinational read, write on the clock edge while strobed.
  logic [31:0] mem [0:31];
  bit          mem_init;
  assign mem_rdata = mem[mem_addr[4:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (mem_write) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  resp_t resp_q[$];
  bit    gnt_q[$];
  int    checks = 0;
  int    errors = 0;
  int    wr_cycles = 0;
  int    rd_cycles = 0;
  logic [31:0] wr_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard for the round-robin instance.
  bit          prev_wr = 1'b0;
  logic [31:0] prev_wr_addr, prev_wr_data;
  resp_t       mon_r;
  bit          mon_g;
  always @(negedge clk) begin
    if (mem_write | mem_read) check("strobe_exclusive", {31'd0, mem_write & mem_read}, 32'd0);
    if (prev_wr) begin
      check("wr_addr_stable_after", mem_addr, prev_wr_addr);
      check("wr_data_stable_after", mem_wdata, prev_wr_data);
    end
    prev_wr = mem_write;
    if (mem_write) begin
      wr_cycles++;
      wr_addr      = mem_addr;
      prev_wr_addr = mem_addr;
      prev_wr_data = mem_wdata;
    end
    if (mem_read) rd_cycles++;
    if (cpu_gnt | dbg_gnt) begin
      if (cpu_gnt & dbg_gnt) check("dual_gnt", 32'd1, 32'd0);
      if (gnt_q.size() == 0) check("unexpected_gnt", 32'd1, 32'd0);
      else begin
        mon_g = gnt_q.pop_front();
        check("gnt_owner", {31'd0, dbg_gnt}, {31'd0, mon_g});
      end
    end
    if (cpu_rvalid | dbg_rvalid) begin
      if (cpu_rvalid & dbg_rvalid) check("dual_rvalid", 32'd1, 32'd0);
      if (resp_q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else begin
        mon_r = resp_q.pop_front();
        check("rvalid_owner", {31'd0, dbg_rvalid}, {31'd0, mon_r.dbg});
        check("rdata", mon_r.dbg ? dbg_rdata : cpu_rdata, mon_r.rdata);
        check("err", {31'd0, mon_r.dbg ? dbg_err : cpu_err}, {31'd0, mon_r.err});
      end
    end
    if (!cpu_rvalid && (cpu_rdata != 0 || cpu_err)) check("cpu_idle_resp", {cpu_err, cpu_rdata[30:0]}, 32'd0);
    if (!dbg_rvalid && (dbg_rdata != 0 || dbg_err)) check("dbg_idle_resp", {dbg_err, dbg_rdata[30:0]}, 32'd0);
  end

  task automatic wait_gnt(input bit dbg, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dbg ? dbg_gnt : cpu_gnt) && n < 12);
    if (!(dbg ? dbg_gnt : cpu_gnt)) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Issue one transaction starting in IDLE; returns in the next IDLE.
  task automatic issue(input bit dbg, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err);
    int n;
    resp_t r;
    r.dbg = dbg; r.rdata = exp_rdata; r.err = exp_err;
    gnt_q.push_back(dbg);
    resp_q.push_back(r);
    if (dbg) begin dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1; end
    else     begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
    wait_gnt(dbg, n);
    check("gnt_latency", n, 32'd2);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, wr0, rd0, rv, cg, dg;
    resp_t r;
    rst_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
    p_cpu_req = 1'b0; p_dbg_req = 1'b0;

    // Reset held two cycles with both requests up.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_ctrl", {26'd0, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_write, mem_read}, 32'd0);
      check("reset_err", {30'd0, cpu_err, dbg_err}, 32'd0);
      check("reset_rdata", cpu_rdata | dbg_rdata, 32'd0);
      check("reset_mem_addr", mem_addr | mem_wdata, 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0; mem_init = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU write then read back.
    issue(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    check("write_strobe_cycles", wr_cycles, 32'd1);
    check("write_strobe_addr", wr_addr, 32'd5);
    issue(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);

    // Out-of-range accesses: no strobes, err set, rdata zero.
    wr0 = wr_cycles; rd0 = rd_cycles;
    issue(1'b1, 1'b0, 32'h20, 32'd0, 32'd0, 1'b1);
    issue(1'b0, 1'b1, 32'h8000_0005, 32'h1111_1111, 32'd0, 1'b1);
    check("oor_no_write", wr_cycles, wr0);
    check("oor_no_read", rd_cycles, rd0);
    issue(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);

    // Debug write, CPU reads it back; preloaded words still intact.
    issue(1'b1, 1'b1, 32'd7, 32'h1234_5678, 32'd0, 1'b0);
    issue(1'b0, 1'b0, 32'd7, 32'd0, 32'h1234_5678, 1'b0);
    issue(1'b1, 1'b0, 32'd31, 32'd0, 32'hA000_001F, 1'b0);

    // Round-robin with both requests held: CPU first after reset, then alternate.
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gnt_q.push_back(i[0]);
      r.dbg = i[0]; r.err = 1'b0;
      r.rdata = i[0] ? 32'hA000_0014 : 32'hA000_000A;
      resp_q.push_back(r);
    end
    cpu_we = 1'b0; cpu_addr = 32'd10; dbg_we = 1'b0; dbg_addr = 32'd20;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(cpu_gnt | dbg_gnt) && n < 12);
      check("rr_gnt_spacing", n, (i == 0) ? 32'd2 : 32'd3);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1;

    // Reset during ACCESS of a CPU read: response is dropped.
    gnt_q.push_back(1'b0);
    cpu_we = 1'b0; cpu_addr = 32'd5; cpu_req = 1'b1;
    wait_gnt(1'b0, n);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_rvalid | cpu_gnt | mem_read | mem_write) rv++;
    end
    check("midreset_quiet", rv, 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'd7, 32'd0, 32'h1234_5678, 1'b0);

    // Fixed priority instance: CPU wins every slot while debug waits.
    p_cpu_req = 1'b1; p_dbg_req = 1'b1;
    cg = 0; dg = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (p_cpu_gnt) cg++;
      if (p_dbg_gnt) dg++;
    end
    check("pri_cpu_gnts", cg, 32'd4);
    check("pri_dbg_gnts", dg, 32'd0);
    @(posedge clk); #1;
    p_cpu_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!p_dbg_gnt && n < 8);
    check("pri_dbg_served", {31'd0, p_dbg_gnt}, 32'd1);
    @(posedge clk); #1;
    p_dbg_req = 1'b0;

    repeat (4) @(posedge clk);
    check("resp_q_drained", resp_q.size(), 32'd0);
    check("gnt_q_drained", gnt_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
